// File: rtl/ula_wb_if.sv
// ula_wb_if: bundle and writeback handshake between the logic ULA, the
// writeback stage and the register file.
//   in_*  : ULA result bundle (valid/ready), driven by the ULA side
//   out_* : writeback bundle (valid/ready), consumed by the register file
// Modports:
//   slave  : the writeback stage's view (sinks in_*, sources out_*)
//   master : the surrounding logic's view (sources in_*, sinks out_*)
interface ula_wb_if #(
    parameter int BITS     = 16,
    parameter int REG_ADDR = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [4:0]          in_op;
    logic [BITS-1:0]     in_result;
    logic                in_o;
    logic                in_c;
    logic                in_s;
    logic                in_z;
    logic [REG_ADDR-1:0] in_dest;
    logic                in_we;

    logic                out_valid;
    logic                out_ready;
    logic [BITS-1:0]     out_data;
    logic [REG_ADDR-1:0] out_dest;
    logic                out_we;

    modport slave (
        input  in_valid, in_op, in_result, in_o, in_c, in_s, in_z, in_dest, in_we,
        output in_ready,
        output out_valid, out_data, out_dest, out_we,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_result, in_o, in_c, in_s, in_z, in_dest, in_we,
        input  in_ready,
        input  out_valid, out_data, out_dest, out_we,
        output out_ready
    );
endinterface

// File: rtl/ula_wb_stage.sv
// ula_wb_stage: writeback and flag stage behind the logic ULA.
//   clk, rst   : clock, asynchronous active-high reset
//   wb         : ula_wb_if.slave - ULA bundle in, writeback bundle out
//   flags_ld   : load the flag register from flags_in (context restore)
//   flags_in   : {O,C,S,Z} load value
//   flags      : {O,C,S,Z} architectural flag register
//   cond       : branch condition code
//   cond_true  : condition evaluated against the registered flags
// The bundle path is a two-entry skid buffer: the main entry drives out_*,
// the skid entry absorbs one extra bundle so in_ready can be registered.
module ula_wb_stage #(
    parameter int BITS     = 16,
    parameter int REG_ADDR = 4
) (
    input  logic       clk,
    input  logic       rst,
    ula_wb_if.slave    wb,
    input  logic       flags_ld,
    input  logic [3:0] flags_in,
    output logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       cond_true
);

    typedef enum logic [1:0] {
        CLS_SHIFT,
        CLS_LOGIC,
        CLS_PASS,
        CLS_UNDEF
    } op_class_t;

    op_class_t           op_class;
    logic [3:0]          upd_mask;
    logic [3:0]          in_flags;
    logic                accept;
    logic                drain;
    logic                new_we;

    logic                main_valid_reg, main_valid_next;
    logic [BITS-1:0]     main_data_reg,  main_data_next;
    logic [REG_ADDR-1:0] main_dest_reg,  main_dest_next;
    logic                main_we_reg,    main_we_next;
    logic                skid_valid_reg, skid_valid_next;
    logic [BITS-1:0]     skid_data_reg,  skid_data_next;
    logic [REG_ADDR-1:0] skid_dest_reg,  skid_dest_next;
    logic                skid_we_reg,    skid_we_next;
    logic                in_ready_reg,   in_ready_next;
    logic [3:0]          flags_reg,      flags_next;

    // Op class decode; everything with op[4] set that is not a pass/const
    // code is a logical op.
    always_comb begin
        op_class = CLS_UNDEF;
        case (wb.in_op)
            5'b01000, 5'b01001: op_class = CLS_SHIFT;
            5'b10011, 5'b11111: op_class = CLS_PASS;
            default:            op_class = wb.in_op[4] ? CLS_LOGIC : CLS_UNDEF;
        endcase
    end

    // Which of {O,C,S,Z} an op class writes.
    always_comb begin
        upd_mask = 4'b0000;
        case (op_class)
            CLS_SHIFT: upd_mask = 4'b0111;
            CLS_LOGIC: upd_mask = 4'b0011;
            default:   upd_mask = 4'b0000;
        endcase
    end

    assign in_flags = {wb.in_o, wb.in_c, wb.in_s, wb.in_z};
    assign accept   = wb.in_valid && in_ready_reg;
    assign drain    = main_valid_reg && wb.out_ready;
    assign new_we   = wb.in_we && (op_class != CLS_UNDEF);

    // Per-bit flag update: a context restore wins over an op-driven write.
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
        assign flags_next[gi] = flags_ld                   ? flags_in[gi] :
                                (accept && upd_mask[gi])   ? in_flags[gi] :
                                                             flags_reg[gi];
    end

    // Skid buffer next state. While skid is occupied in_ready is low, so
    // no accept can coincide with a skid-to-main move.
    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        main_dest_next  = main_dest_reg;
        main_we_next    = main_we_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_dest_next  = skid_dest_reg;
        skid_we_next    = skid_we_reg;
        if (skid_valid_reg) begin
            if (drain) begin
                main_data_next  = skid_data_reg;
                main_dest_next  = skid_dest_reg;
                main_we_next    = skid_we_reg;
                skid_valid_next = 1'b0;
            end
        end else if (!main_valid_reg || drain) begin
            main_valid_next = accept;
            if (accept) begin
                main_data_next = wb.in_result;
                main_dest_next = wb.in_dest;
                main_we_next   = new_we;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_data_next  = wb.in_result;
            skid_dest_next  = wb.in_dest;
            skid_we_next    = new_we;
        end
        in_ready_next = !skid_valid_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_dest_reg  <= '0;
            main_we_reg    <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_dest_reg  <= '0;
            skid_we_reg    <= 1'b0;
            in_ready_reg   <= 1'b0;
            flags_reg      <= 4'b0000;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            main_dest_reg  <= main_dest_next;
            main_we_reg    <= main_we_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_dest_reg  <= skid_dest_next;
            skid_we_reg    <= skid_we_next;
            in_ready_reg   <= in_ready_next;
            flags_reg      <= flags_next;
        end
    end

    assign wb.in_ready  = in_ready_reg;
    assign wb.out_valid = main_valid_reg;
    assign wb.out_data  = main_data_reg;
    assign wb.out_dest  = main_dest_reg;
    assign wb.out_we    = main_valid_reg && main_we_reg;
    assign flags        = flags_reg;

    // Branch condition against the registered {O,C,S,Z}.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true = 1'b1;
            4'b0001: cond_true = flags_reg[0];
            4'b0010: cond_true = !flags_reg[0];
            4'b0011: cond_true = flags_reg[1];
            4'b0100: cond_true = !flags_reg[1];
            4'b0101: cond_true = flags_reg[2];
            4'b0110: cond_true = !flags_reg[2];
            4'b0111: cond_true = flags_reg[3];
            4'b1000: cond_true = !flags_reg[3];
            4'b1001: cond_true = flags_reg[1] ^ flags_reg[3];
            4'b1010: cond_true = !(flags_reg[1] ^ flags_reg[3]) && !flags_reg[0];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ula_wb_stage.sv
// tb_ula_wb_stage: scoreboard bench for ula_wb_stage. The driver pushes
// expected writeback bundles and tracks the flag register with a small
// model; a negedge monitor pops and compares on every delivery.
module tb_ula_wb_stage;

    logic       clk;
    logic       rst;
    logic       flags_ld;
    logic [3:0] flags_in;
    logic [3:0] flags;
    logic [3:0] cond;
    logic       cond_true;

    ula_wb_if #(.BITS(16), .REG_ADDR(4)) wb ();

    ula_wb_stage #(.BITS(16), .REG_ADDR(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb        (wb),
        .flags_ld  (flags_ld),
        .flags_in  (flags_in),
        .flags     (flags),
        .cond      (cond),
        .cond_true (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dest;
        logic        we;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  mflags;
    int          tests;
    int          fails;
    bit          mon_en;

    // What was driven for the edge that has not been booked yet.
    bit          p_acc;
    bit          p_fld;
    logic [3:0]  p_fin;
    logic [4:0]  p_op;
    logic [3:0]  p_f;
    logic [15:0] p_res;
    logic [3:0]  p_dest;
    bit          p_we;

    // Stability tracking for stalled outputs.
    bit          hold_v;
    logic [15:0] hold_data;
    logic [3:0]  hold_dest;
    logic        hold_we;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // 0 = undefined, 1 = shift, 2 = logical, 3 = pass/const
    function automatic int op_kind(logic [4:0] op);
        if (op == 5'd8 || op == 5'd9)   return 1;
        if (op == 5'd19 || op == 5'd31) return 3;
        if (op >= 5'd16)                return 2;
        return 0;
    endfunction

    function automatic bit cond_model(logic [3:0] f, logic [3:0] c);
        bit o, cy, s, z;
        o = f[3]; cy = f[2]; s = f[1]; z = f[0];
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return z;
            4'd2:  return !z;
            4'd3:  return s;
            4'd4:  return !s;
            4'd5:  return cy;
            4'd6:  return !cy;
            4'd7:  return o;
            4'd8:  return !o;
            4'd9:  return s != o;
            4'd10: return (s == o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    // Apply the edge that just passed to the model.
    task automatic book();
        exp_t e;
        if (p_acc) begin
            e.data = p_res;
            e.dest = p_dest;
            e.we   = p_we && (op_kind(p_op) != 0);
            sb.push_back(e);
        end
        if (p_fld)
            mflags = p_fin;
        else if (p_acc && op_kind(p_op) == 1)
            mflags = {mflags[3], p_f[2:0]};
        else if (p_acc && op_kind(p_op) == 2)
            mflags = {mflags[3:2], p_f[1:0]};
    endtask

    task automatic step(input bit v, input logic [4:0] op, input logic [15:0] res,
                        input logic [3:0] f, input logic [3:0] dest, input bit we,
                        input bit ordy, input bit fld, input logic [3:0] fin,
                        input logic [3:0] cnd, output bit acc);
        @(posedge clk);
        #2;
        book();
        wb.in_valid  = v;
        wb.in_op     = op;
        wb.in_result = res;
        wb.in_o      = f[3];
        wb.in_c      = f[2];
        wb.in_s      = f[1];
        wb.in_z      = f[0];
        wb.in_dest   = dest;
        wb.in_we     = we;
        wb.out_ready = ordy;
        flags_ld     = fld;
        flags_in     = fin;
        cond         = cnd;
        acc    = v && wb.in_ready;
        p_acc  = acc;
        p_fld  = fld;
        p_fin  = fin;
        p_op   = op;
        p_f    = f;
        p_res  = res;
        p_dest = dest;
        p_we   = we;
    endtask

    task automatic idle(input bit ordy, input logic [3:0] cnd);
        bit a;
        step(1'b0, 5'd0, 16'd0, 4'd0, 4'd0, 1'b0, ordy, 1'b0, 4'd0, cnd, a);
    endtask

    // Monitor: handshake occupancy, flags, condition, stability, delivery.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("in_ready", {31'd0, wb.in_ready}, {31'd0, sb.size() < 2});
            check("flags", {28'd0, flags}, {28'd0, mflags});
            check("cond_true", {31'd0, cond_true}, {31'd0, cond_model(mflags, cond)});
            if (hold_v) begin
                check("stall_stable", {11'd0, wb.out_valid, wb.out_data, wb.out_dest, wb.out_we},
                      {11'd0, 1'b1, hold_data, hold_dest, hold_we});
            end
            if (wb.out_valid && wb.out_ready) begin
                if (sb.size() == 0) begin
                    check("stale_bundle", {31'd0, wb.out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_bundle", {11'd0, wb.out_data, wb.out_dest, wb.out_we},
                          {11'd0, e.data, e.dest, e.we});
                    $display("[TB] deliver data=%h dest=%0d we=%0d", wb.out_data, wb.out_dest, wb.out_we);
                end
            end
            hold_v    = wb.out_valid && !wb.out_ready;
            hold_data = wb.out_data;
            hold_dest = wb.out_dest;
            hold_we   = wb.out_we;
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        bit a, a1, a2, a3;
        int n;
        tests = 0; fails = 0; mon_en = 0; mflags = 4'b0000;
        p_acc = 0; p_fld = 0; p_fin = 0; p_op = 0; p_f = 0; p_res = 0; p_dest = 0; p_we = 0;
        hold_v = 0;
        wb.in_valid = 0; wb.in_op = 0; wb.in_result = 0; wb.in_o = 0; wb.in_c = 0;
        wb.in_s = 0; wb.in_z = 0; wb.in_dest = 0; wb.in_we = 0; wb.out_ready = 0;
        flags_ld = 0; flags_in = 0; cond = 0;

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, wb.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, wb.out_valid}, 32'd0);
        check("rst_out_data", {16'd0, wb.out_data}, 32'd0);
        check("rst_out_dest", {28'd0, wb.out_dest}, 32'd0);
        check("rst_out_we", {31'd0, wb.out_we}, 32'd0);
        check("rst_flags", {28'd0, flags}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1, 4'd0);
        check("post_rst_in_ready", {31'd0, wb.in_ready}, 32'd1);
        mon_en = 1'b1;

        // Logical op sets Z; one-cycle latency
        step(1'b1, 5'b10001, 16'h0000, 4'b0001, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 4'b0001, a);
        idle(1'b1, 4'b0001);
        #1;
        check("t1_out", {11'd0, wb.out_valid, wb.out_data, wb.out_dest, wb.out_we},
              {11'd0, 1'b1, 16'h0000, 4'd3, 1'b1});
        check("t1_flags", {28'd0, flags}, 32'b0001);
        check("t1_cond", {31'd0, cond_true}, 32'd1);
        $display("[TB] t1 flags=%b cond_true=%0d", flags, cond_true);

        // Back-pressure: two fit, third refused
        step(1'b1, 5'b10011, 16'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, a1);
        step(1'b1, 5'b10011, 16'd2, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, a2);
        step(1'b1, 5'b10011, 16'd3, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, a3);
        check("t2_acc1", {31'd0, a1}, 32'd1);
        check("t2_acc2", {31'd0, a2}, 32'd1);
        check("t2_acc3_refused", {31'd0, a3}, 32'd0);
        $display("[TB] t2 stalled accepts=%0d%0d%0d", a1, a2, a3);
        n = 0;
        a = 1'b0;
        while (!a && n < 10) begin
            step(1'b1, 5'b10011, 16'd3, 4'd0, 4'd3, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, a);
            n++;
        end
        check("t2_resend_accepted", {31'd0, a}, 32'd1);
        repeat (4) idle(1'b1, 4'd0);
        check("t2_in_ready_back", {31'd0, wb.in_ready}, 32'd1);

        // Shift keeps O; pass leaves flags
        step(1'b0, 5'd0, 16'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'b1100, 4'd0, a);
        step(1'b1, 5'b01000, 16'h1234, 4'b0010, 4'd5, 1'b1, 1'b1, 1'b0, 4'd0, 4'd7, a);
        step(1'b1, 5'b10011, 16'h5678, 4'b0001, 4'd6, 1'b1, 1'b1, 1'b0, 4'd0, 4'd9, a);
        check("t3_shift_flags", {28'd0, flags}, 32'b1010);
        idle(1'b1, 4'd10);
        check("t3_pass_flags", {28'd0, flags}, 32'b1010);
        $display("[TB] t3 flags=%b", flags);

        // flags_ld beats logical op update
        step(1'b1, 5'b10110, 16'h00ff, 4'b0010, 4'd7, 1'b1, 1'b1, 1'b1, 4'b0101, 4'd5, a);
        idle(1'b1, 4'd5);
        check("t4_ld_priority", {28'd0, flags}, 32'b0101);

        // Undefined op forwarded without write
        step(1'b1, 5'b00111, 16'hbeef, 4'b1111, 4'd9, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, a);
        idle(1'b1, 4'd0);
        #1;
        check("t5_undef_out", {11'd0, wb.out_valid, wb.out_data, wb.out_dest, wb.out_we},
              {11'd0, 1'b1, 16'hbeef, 4'd9, 1'b0});
        check("t5_undef_flags", {28'd0, flags}, 32'b0101);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom), 16'($urandom), 4'($urandom),
                 4'($urandom), 1'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 11) == 0, 4'($urandom), 4'($urandom), a);
        end
        n = 0;
        while ((sb.size() != 0 || wb.out_valid) && n < 20) begin
            idle(1'b1, 4'($urandom));
            n++;
        end
        check("drain_empty", sb.size(), 32'd0);

        // Asynchronous reset with both entries full
        step(1'b1, 5'b10011, 16'haaaa, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, a);
        step(1'b1, 5'b10011, 16'hbbbb, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, a);
        idle(1'b0, 4'd0);
        check("t6_full_in_ready", {31'd0, wb.in_ready}, 32'd0);
        #2;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", {31'd0, wb.out_valid}, 32'd0);
        check("t6_rst_flags", {28'd0, flags}, 32'd0);
        check("t6_rst_in_ready", {31'd0, wb.in_ready}, 32'd0);
        sb.delete();
        mflags = 4'b0000;
        p_acc = 0;
        p_fld = 0;
        wb.in_valid = 0;
        wb.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1'b1, 4'd0);
        check("t6_release_in_ready", {31'd0, wb.in_ready}, 32'd1);
        check("t6_release_out_valid", {31'd0, wb.out_valid}, 32'd0);
        mon_en = 1'b1;
        repeat (5) idle(1'b1, 4'($urandom));
        idle(1'b1, 4'd0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ula_wb_stage.md
Name: ula_wb_stage

Overview:
- Writeback and flag stage directly downstream of the logic ULA.
- Registers the ULA result, destination register and flags behind a valid/ready handshake with a 2-entry skid buffer.
- Keeps the architectural O/C/S/Z flag register, updated per op class.
- Evaluates a branch condition code against the flag register for the fetch/branch unit.

Parameters:
- BITS, 16, data width; matches the ULA result width.
- REG_ADDR, 4, width of the register-file destination address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ULA output bundle is valid.
- in_ready  out  1  stage can accept the bundle this cycle.
- in_op  in  5  op code that produced the bundle (ULA encoding).
- in_result  in  BITS  ULA RESU.
- in_o, in_c, in_s, in_z  in  1 each  ULA flags.
- in_dest  in  REG_ADDR  destination register.
- in_we  in  1  request register-file write.
- out_valid  out  1  writeback bundle valid.
- out_ready  in  1  register file accepts the bundle.
- out_data  out  BITS  result to write.
- out_dest  out  REG_ADDR  destination.
- out_we  out  1  write enable; qualified by out_valid.
- flags_ld  in  1  load the flag register from flags_in (context restore).
- flags_in  in  4  {O,C,S,Z} load value.
- flags  out  4  {O,C,S,Z} flag register.
- cond  in  4  condition code.
- cond_true  out  1  condition result, combinational from the flag register.

Behaviour:
- Reset, asynchronous: both buffer entries invalid; out_valid=0; out_data=0; out_dest=0; out_we=0; flags=4'b0000; in_ready=0 while rst is high and 1 on the first cycle after release.
- Accept on in_valid&&in_ready. Deliver on out_valid&&out_ready.
- Latency: a bundle accepted in cycle N is visible on out_* in cycle N+1 when the main entry is empty or draining.
- Buffer: main entry drives out_*; the skid entry holds one extra bundle.
  - in_ready is registered and equals !skid_valid.
  - Accept while main is full and not draining: the bundle goes to skid; in_ready=0 next cycle.
  - Main drains while skid is valid: skid moves to main in the same edge; in_ready=1 next cycle.
  - Accept and drain in the same cycle with skid empty: the new bundle goes straight to main.
  - Strict FIFO order; no bundle is dropped or duplicated.
  - out_* stay stable while out_valid && !out_ready.
- Op classes decode in_op at acceptance:
  - Shift (01000, 01001): flags C, S, Z take the in_ values; O is retained.
  - Logical (10000–10010, 10100–11110): flags S, Z take the in_ values; O, C are retained.
  - Pass/const (10011, 11111): flags unchanged.
  - Undefined codes: flags unchanged; the bundle is forwarded with out_we forced to 0.
- Flag update happens on the acceptance edge, independent of output stall.
- flags_ld has priority over an op-driven update in the same cycle.
- cond_true is evaluated on the registered flags:
  - 0000 → 1
  - 0001 → Z
  - 0010 → !Z
  - 0011 → S
  - 0100 → !S
  - 0101 → C
  - 0110 → !C
  - 0111 → O
  - 1000 → !O
  - 1001 → S^O
  - 1010 → !(S^O)&&!Z
  - 1011–1111 → 0
- Reset mid-operation: buffered bundles are discarded; nothing is delivered after rst rises.
- Widths: data passes through unmodified; no arithmetic is done in this stage.

Test Plan:
- Reset, then send op 10001, result 16'h0000, z=1, s=0, dest 3, we=1, out_ready=1 → next cycle out_valid=1, out_data=0, out_dest=3, out_we=1; flags=4'b0001; cond 0001 → cond_true=1.
- Hold out_ready=0, send three bundles (results 1, 2, 3) back-to-back → first two accepted, in_ready=0 on the third; raise out_ready → outputs 1, 2, 3 in order; in_ready returns to 1.
- Flags=4'b1100 via flags_ld, then shift op 01000 with c=0, s=1, z=0 → flags=4'b1010 (O kept); then op 10011 with z=1 → flags still 4'b1010.
- flags_ld=1 with flags_in=4'b0101 in the same cycle as accepting logical op 10110 (s=1, z=0) → flags=4'b0101.
- Undefined op 00111 with we=1 → forwarded with out_we=0; flags unchanged.
- Skid full and main full, assert rst asynchronously mid-cycle → out_valid=0 and flags=0 immediately; after release in_ready=1 and no stale bundle appears.
